fifo_rd_pack: RTL and testbench



---
 rtl/fifo_rd_pack_if.sv | 30 +++
 rtl/fifo_rd_pack.sv | 135 +++++++++++++
 tb/tb_fifo_rd_pack.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_pack_if.sv
// fifo_rd_pack_if: handshake bundle between an upstream fifo read port, the
// packer, and a wide-word consumer.
//   in_dat/in_val/in_pop : fifo dout / dout_val / pop
//   flush                : level request to emit a partially filled word
//   out_dat/out_cnt      : packed word and number of valid lanes (1..RATIO)
//   out_val/out_rdy      : output valid/ready handshake
// Modports: master = the packer, slave = the surrounding fifo + consumer.
interface fifo_rd_pack_if #(
  parameter int WIDTH = 8,
  parameter int RATIO = 4
);
  logic [WIDTH-1:0]       in_dat;
  logic                   in_val;
  logic                   in_pop;
  logic                   flush;
  logic [WIDTH*RATIO-1:0] out_dat;
  logic [$clog2(RATIO):0] out_cnt;
  logic                   out_val;
  logic                   out_rdy;

  modport master (
    input  in_dat, in_val, flush, out_rdy,
    output in_pop, out_dat, out_cnt, out_val
  );

  modport slave (
    output in_dat, in_val, flush, out_rdy,
    input  in_pop, out_dat, out_cnt, out_val
  );
endinterface

// File: rtl/fifo_rd_pack.sv
// fifo_rd_pack: pops WIDTH-bit entries from a fifo and packs RATIO of them
// into one wide word on a valid/ready port. Lane k is out_dat[k*WIDTH +: WIDTH].
// A flush emits a partially filled word; unused lanes read 0.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : fifo_rd_pack_if.master (fifo read side, flush, output word)
// Optional build macro PACK_TMO_EN: adds an idle timer that behaves like a
// flush after TMO_CYC idle cycles with a partial word pending.
//
// state | meaning
// FILL  | collecting entries into lanes, out_val=0
// HOLD  | word presented, out_val=1, contents frozen until accepted
module fifo_rd_pack #(
  parameter int WIDTH   = 8,
  parameter int RATIO   = 4,
  parameter int TMO_CYC = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  fifo_rd_pack_if.master bus
);

  localparam int CNT_W  = $clog2(RATIO);
  localparam int OCNT_W = $clog2(RATIO) + 1;

  if (RATIO < 2 || RATIO > 16 || TMO_CYC < 1) begin : g_param_check
    $error("fifo_rd_pack: RATIO must be 2..16 and TMO_CYC >= 1");
  end

  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

  state_t                       state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [RATIO-1:0][WIDTH-1:0]  lanes_q, lanes_d;
  logic [OCNT_W-1:0]            out_cnt_q, out_cnt_d;
  logic                         pop;
  logic                         tmo_hit;
  logic                         flush_eff;

  // Pop in FILL whenever data is there; in HOLD only when the held word is
  // leaving this cycle, which keeps one word per RATIO cycles.
  assign pop       = bus.in_val & ((state_q == FILL) | bus.out_rdy);
  assign flush_eff = bus.flush | tmo_hit;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lanes_d   = lanes_q;
    out_cnt_d = out_cnt_q;
    case (state_q)
      FILL: begin
        if (pop) begin
          lanes_d[cnt_q] = bus.in_dat;
          if (cnt_q == CNT_W'(RATIO - 1)) begin
            state_d   = HOLD;
            out_cnt_d = OCNT_W'(RATIO);
            cnt_d     = '0;
          end else if (flush_eff) begin
            // entry popped alongside the flush is part of the emitted word
            state_d   = HOLD;
            out_cnt_d = OCNT_W'(cnt_q) + OCNT_W'(1);
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (flush_eff && (cnt_q != '0)) begin
          state_d   = HOLD;
          out_cnt_d = OCNT_W'(cnt_q);
          cnt_d     = '0;
        end
      end
      HOLD: begin
        if (bus.out_rdy) begin
          state_d   = FILL;
          lanes_d   = '0;
          out_cnt_d = '0;
          if (pop) begin
            lanes_d[0] = bus.in_dat;
            cnt_d      = CNT_W'(1);
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FILL;
      cnt_q     <= '0;
      lanes_q   <= '0;
      out_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lanes_q   <= lanes_d;
      out_cnt_q <= out_cnt_d;
    end
  end

`ifdef PACK_TMO_EN
  localparam int TMO_W = $clog2(TMO_CYC + 1);

  logic [TMO_W-1:0] tmo_q, tmo_d;

  // Counts only while a partial word sits idle; it cannot pass TMO_CYC
  // because reaching it forces the move to HOLD, which clears it.
  always_comb begin
    tmo_d = tmo_q;
    if ((state_q != FILL) || pop || (state_d == HOLD)) begin
      tmo_d = '0;
    end else if (cnt_q != '0) begin
      tmo_d = tmo_q + TMO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end

  assign tmo_hit = (tmo_q == TMO_W'(TMO_CYC));
`else
  assign tmo_hit = 1'b0;
`endif

  assign bus.in_pop  = pop;
  assign bus.out_dat = lanes_q;
  assign bus.out_cnt = out_cnt_q;
  assign bus.out_val = (state_q == HOLD);

endmodule

// File: tb/tb_fifo_rd_pack.sv
// Directed bench for fifo_rd_pack with WIDTH=8, RATIO=4. A queue models the
// upstream fifo; accepted words are captured into rx queues.
module tb_fifo_rd_pack;

  localparam int WIDTH = 8;
  localparam int RATIO = 4;

  logic clk;
  logic rst_n;

  fifo_rd_pack_if #(.WIDTH(WIDTH), .RATIO(RATIO)) bus ();

  fifo_rd_pack #(.WIDTH(WIDTH), .RATIO(RATIO), .TMO_CYC(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  fifo_q [$];
  logic [31:0] rx_dat [$];
  logic [2:0]  rx_cnt [$];
  logic        last_pop;

  task automatic drive();
    bus.in_val = (fifo_q.size() != 0);
    bus.in_dat = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
  endtask

  // Entered and left at posedge+1. Samples settled combinational outputs,
  // captures an accepted word, crosses one edge, then updates the fifo model.
  task automatic tick();
    logic p;
    #1;
    p = bus.in_pop;
    last_pop = p;
    if (bus.out_val && bus.out_rdy) begin
      rx_dat.push_back(bus.out_dat);
      rx_cnt.push_back(bus.out_cnt);
    end
    @(posedge clk);
    #1;
    if (p && fifo_q.size() != 0) void'(fifo_q.pop_front());
    drive();
  endtask

  task automatic push(input logic [7:0] d);
    fifo_q.push_back(d);
    drive();
  endtask

  task automatic test_reset();
    bus.flush = 1'b0; bus.out_rdy = 1'b1; bus.in_val = 1'b0; bus.in_dat = 8'h00;
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    n_cmp++; if (bus.out_val !== 1'b0) begin n_err++; $display("FAIL reset_val: got %b want 0", bus.out_val); end
    n_cmp++; if (bus.out_dat !== 32'h0) begin n_err++; $display("FAIL reset_dat: got %h want 00000000", bus.out_dat); end
    n_cmp++; if (bus.out_cnt !== 3'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", bus.out_cnt); end
    n_cmp++; if (bus.in_pop !== 1'b0) begin n_err++; $display("FAIL reset_pop: got %b want 0", bus.in_pop); end
    @(posedge clk); #1;
  endtask

  task automatic test_single_word();
    int pops;
    pops = 0;
    bus.out_rdy = 1'b1;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (last_pop) pops++;
    end
    n_cmp++; if (pops !== 4) begin n_err++; $display("FAIL single_pops: got %0d want 4", pops); end
    n_cmp++; if (bus.out_val !== 1'b1) begin n_err++; $display("FAIL single_latency: out_val got %b want 1", bus.out_val); end
    n_cmp++; if (bus.out_dat !== 32'h44332211) begin n_err++; $display("FAIL single_dat: got %h want 44332211", bus.out_dat); end
    n_cmp++; if (bus.out_cnt !== 3'd4) begin n_err++; $display("FAIL single_cnt: got %0d want 4", bus.out_cnt); end
    tick();
    n_cmp++; if (rx_dat.size() !== 1) begin n_err++; $display("FAIL single_rx: got %0d words want 1", rx_dat.size()); end
    n_cmp++; if (bus.out_val !== 1'b0) begin n_err++; $display("FAIL single_release: out_val got %b want 0", bus.out_val); end
    rx_dat.delete(); rx_cnt.delete();
  endtask

  task automatic test_back_to_back();
    int pops;
    pops = 0;
    bus.out_rdy = 1'b1;
    for (int i = 1; i <= 8; i++) push(8'(i * 8'h11));
    for (int i = 0; i < 8; i++) begin
      tick();
      if (last_pop) pops++;
    end
    tick();
    tick();
    n_cmp++; if (pops !== 8) begin n_err++; $display("FAIL b2b_pops: got %0d in 8 cycles want 8", pops); end
    n_cmp++; if (rx_dat.size() !== 2) begin n_err++; $display("FAIL b2b_rx: got %0d words want 2", rx_dat.size()); end
    if (rx_dat.size() == 2) begin
      n_cmp++; if (rx_dat[0] !== 32'h44332211) begin n_err++; $display("FAIL b2b_w0: got %h want 44332211", rx_dat[0]); end
      n_cmp++; if (rx_dat[1] !== 32'h88776655) begin n_err++; $display("FAIL b2b_w1: got %h want 88776655", rx_dat[1]); end
      n_cmp++; if (rx_cnt[1] !== 3'd4) begin n_err++; $display("FAIL b2b_cnt: got %0d want 4", rx_cnt[1]); end
    end
    rx_dat.delete(); rx_cnt.delete();
  endtask

  task automatic test_flush();
    bus.out_rdy = 1'b1;
    // flush with nothing collected does nothing
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    n_cmp++; if (bus.out_val !== 1'b0) begin n_err++; $display("FAIL flush_empty: out_val got %b want 0", bus.out_val); end
    // flush after two entries, no pop in the flush cycle
    push(8'hA1); push(8'hA2);
    tick(); tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    n_cmp++; if (bus.out_val !== 1'b1) begin n_err++; $display("FAIL flush_val: got %b want 1", bus.out_val); end
    n_cmp++; if (bus.out_dat !== 32'h0000A2A1) begin n_err++; $display("FAIL flush_dat: got %h want 0000A2A1", bus.out_dat); end
    n_cmp++; if (bus.out_cnt !== 3'd2) begin n_err++; $display("FAIL flush_cnt: got %0d want 2", bus.out_cnt); end
    tick();
    // flush coinciding with a pop includes the popped entry
    push(8'hB1); push(8'hB2);
    tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    n_cmp++; if (bus.out_dat !== 32'h0000B2B1) begin n_err++; $display("FAIL flush_pop_dat: got %h want 0000B2B1", bus.out_dat); end
    n_cmp++; if (bus.out_cnt !== 3'd2) begin n_err++; $display("FAIL flush_pop_cnt: got %0d want 2", bus.out_cnt); end
    tick();
    n_cmp++; if (rx_dat.size() !== 2) begin n_err++; $display("FAIL flush_rx: got %0d words want 2", rx_dat.size()); end
    rx_dat.delete(); rx_cnt.delete();
  endtask

  task automatic test_backpressure();
    int bad_pop, bad_dat;
    bad_pop = 0; bad_dat = 0;
    bus.out_rdy = 1'b0;
    for (int i = 1; i <= 12; i++) push(8'(i));
    for (int i = 0; i < 4; i++) tick();
    for (int i = 0; i < 10; i++) begin
      bus.flush = (i == 5);
      tick();
      if (last_pop !== 1'b0) bad_pop++;
      if (bus.out_dat !== 32'h04030201 || bus.out_cnt !== 3'd4 || bus.out_val !== 1'b1) bad_dat++;
    end
    bus.flush = 1'b0;
    n_cmp++; if (bad_pop !== 0) begin n_err++; $display("FAIL bp_pop: got %0d popping cycles want 0", bad_pop); end
    n_cmp++; if (bad_dat !== 0) begin n_err++; $display("FAIL bp_stable: got %0d unstable cycles want 0", bad_dat); end
    bus.out_rdy = 1'b1;
    for (int i = 0; i < 20 && rx_dat.size() < 3; i++) tick();
    n_cmp++; if (rx_dat.size() !== 3) begin n_err++; $display("FAIL bp_rx: got %0d words want 3", rx_dat.size()); end
    if (rx_dat.size() == 3) begin
      n_cmp++; if (rx_dat[0] !== 32'h04030201) begin n_err++; $display("FAIL bp_w0: got %h want 04030201", rx_dat[0]); end
      n_cmp++; if (rx_dat[1] !== 32'h08070605) begin n_err++; $display("FAIL bp_w1: got %h want 08070605", rx_dat[1]); end
      n_cmp++; if (rx_dat[2] !== 32'h0C0B0A09) begin n_err++; $display("FAIL bp_w2: got %h want 0C0B0A09", rx_dat[2]); end
    end
    tick();
    rx_dat.delete(); rx_cnt.delete();
  endtask

  task automatic test_async_reset();
    bus.out_rdy = 1'b1;
    push(8'hC1); push(8'hC2);
    tick(); tick();
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.out_val !== 1'b0) begin n_err++; $display("FAIL arst_val: got %b want 0", bus.out_val); end
    n_cmp++; if (bus.out_dat !== 32'h0) begin n_err++; $display("FAIL arst_dat: got %h want 00000000", bus.out_dat); end
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    push(8'hD1); push(8'hD2); push(8'hD3); push(8'hD4);
    for (int i = 0; i < 4; i++) tick();
    n_cmp++; if (bus.out_dat !== 32'hD4D3D2D1) begin n_err++; $display("FAIL arst_word: got %h want D4D3D2D1", bus.out_dat); end
    n_cmp++; if (bus.out_cnt !== 3'd4) begin n_err++; $display("FAIL arst_cnt: got %0d want 4", bus.out_cnt); end
    tick();
    rx_dat.delete(); rx_cnt.delete();
  endtask

  task automatic test_idle();
    bus.out_rdy = 1'b1;
    push(8'h5A);
    tick();
`ifdef PACK_TMO_EN
    for (int i = 0; i < 16; i++) tick();
    n_cmp++; if (bus.out_val !== 1'b0) begin n_err++; $display("FAIL tmo_early: out_val got %b want 0", bus.out_val); end
    tick();
    n_cmp++; if (bus.out_val !== 1'b1) begin n_err++; $display("FAIL tmo_fire: out_val got %b want 1", bus.out_val); end
`else
    for (int i = 0; i < 30; i++) tick();
    n_cmp++; if (bus.out_val !== 1'b0) begin n_err++; $display("FAIL idle_hold: out_val got %b want 0", bus.out_val); end
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
`endif
    n_cmp++; if (bus.out_dat !== 32'h0000005A) begin n_err++; $display("FAIL idle_dat: got %h want 0000005A", bus.out_dat); end
    n_cmp++; if (bus.out_cnt !== 3'd1) begin n_err++; $display("FAIL idle_cnt: got %0d want 1", bus.out_cnt); end
    tick();
  endtask

  initial begin
    last_pop = 1'b0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_flush();
    test_backpressure();
    test_async_reset();
    test_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
